// File: rtl/core_pkg.sv
// Shared core definitions: opcode map, branch-select codes, fetch FSM states.
// Latency: none (types and constants only).
// Backpressure: none.
package core_pkg;

  // 4-bit opcode field, top bits of every 9-bit instruction
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_LW   = 4'b0111,
    OP_SW   = 4'b1000,
    OP_LI   = 4'b1001,
    OP_MOV  = 4'b1010,
    OP_CMP  = 4'b1011,
    OP_BE   = 4'b1100,
    OP_BNE  = 4'b1101,
    OP_NOP  = 4'b1110,
    OP_JUMP = 4'b1111
  } opcode_e;

  // Branch-select (MUX7) codes from the control unit; code 3 is reserved
  localparam logic [1:0] BR_EQ  = 2'd0;
  localparam logic [1:0] BR_NE  = 2'd1;
  localparam logic [1:0] BR_JMP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  // Saturating 16-bit increment used by the instruction counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_branch_resolve.sv
// Branch resolution: decides taken/not-taken, next PC and the halt condition.
// Latency: purely combinational, same cycle as the issuing instruction.
// Backpressure: none; result is consumed at the edge ending the cycle.
module fetch_branch_resolve
  import core_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            branch,
  input  logic [1:0]      branch_sel,
  input  logic            eq_flag,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] next_pc,
  output logic            halt
);

  logic taken;

  // Taken decision; the reserved select never branches
  always_comb begin
    taken = 1'b0;
    if (branch) begin
      case (branch_sel)
        BR_EQ:   taken = eq_flag;
        BR_NE:   taken = !eq_flag;
        BR_JMP:  taken = 1'b1;
        default: taken = 1'b0;
      endcase
    end
  end

  // Next PC (sequential wraps naturally at 2^PC_W); a taken branch to itself is a halt
  always_comb begin
    next_pc = taken ? target : pc + PC_W'(1);
    halt    = taken && (target == pc);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, splits the instruction, runs start/done handshake.
// Latency: opcode/operand combinational from imem_data; PC updates each RUN edge.
// Backpressure: none; one instruction per RUN cycle. FETCH_CYCLE_COUNT_EN enables cycle_count.
module fetch_unit
  import core_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int INSTR_W    = 9,
  parameter int START_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [3:0]         opcode,
  output logic [INSTR_W-5:0] operand,
  output logic               instr_valid,
  input  logic               branch,
  input  logic [1:0]         branch_sel,
  input  logic               eq_flag,
  input  logic [PC_W-1:0]    target,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic [15:0]        cycle_count
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] br_next_pc;
  logic            br_halt;

  fetch_branch_resolve #(
    .PC_W(PC_W)
  ) u_resolve (
    .branch    (branch),
    .branch_sel(branch_sel),
    .eq_flag   (eq_flag),
    .target    (target),
    .pc        (pc_q),
    .next_pc   (br_next_pc),
    .halt      (br_halt)
  );

  // Next state and PC; branch inputs only matter while running
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        pc_d = START_PC;
        if (start) state_d = RUN;
      end
      RUN: begin
        pc_d = br_next_pc;
        if (br_halt) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_PC;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
      end
    endcase
  end

  // State and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count every RUN edge (saturating), hold in DONE, clear on (re)start
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RUN) begin
      cnt_d = sat_inc16(cnt_q);
    end else if (start) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign opcode      = imem_data[INSTR_W-1 -: 4];
  assign operand     = imem_data[INSTR_W-5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a 10-bit-PC instance for the main program and a 4-bit-PC
// instance for wrap-around; both tracked by a behavioural model, plus literal checks.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       br   [2];
  logic [1:0] bsel [2];
  logic       eqf  [2];
  logic [9:0] tgt  [2];

  logic [9:0]  a0, pc0;
  logic [8:0]  d0;
  logic [3:0]  op0;
  logic [4:0]  opr0;
  logic        iv0, dn0;
  logic [15:0] cc0;

  logic [3:0]  a1, pc1;
  logic [8:0]  d1;
  logic [3:0]  op1;
  logic [4:0]  opr1;
  logic        iv1, dn1;
  logic [15:0] cc1;

  int compared   = 0;
  int mismatched = 0;

  // Instruction ROM contents as a pure function of address
  function automatic logic [8:0] rom_word(input int addr);
    return 9'((addr * 37 + 5) & 'h1FF);
  endfunction

  assign d0 = rom_word(int'(a0));
  assign d1 = rom_word(int'(a1));

  fetch_unit #(.PC_W(10), .INSTR_W(9), .START_ADDR(0)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(a0), .imem_data(d0), .opcode(op0), .operand(opr0),
    .instr_valid(iv0), .branch(br[0]), .branch_sel(bsel[0]), .eq_flag(eqf[0]),
    .target(tgt[0]), .pc(pc0), .done(dn0), .cycle_count(cc0)
  );

  fetch_unit #(.PC_W(4), .INSTR_W(9), .START_ADDR(0)) u_small (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(a1), .imem_data(d1), .opcode(op1), .operand(opr1),
    .instr_valid(iv1), .branch(br[1]), .branch_sel(bsel[1]), .eq_flag(eqf[1]),
    .target(tgt[1][3:0]), .pc(pc1), .done(dn1), .cycle_count(cc1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 done
  int m_mode [2];
  int m_pc   [2];
  int m_cnt  [2];
  bit armed = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  modv;
      int  t;
      bit  take;
      modv = (d == 0) ? 1024 : 16;
      t    = int'(tgt[d]) % modv;
      if (reset) begin
        m_mode[d] = 0; m_pc[d] = 0; m_cnt[d] = 0;
      end else if (m_mode[d] == 0) begin
        if (start) begin m_mode[d] = 1; m_cnt[d] = 0; end
      end else if (m_mode[d] == 1) begin
        take = br[d] && ((bsel[d] == 2'd0 && eqf[d]) || (bsel[d] == 2'd1 && !eqf[d]) || bsel[d] == 2'd2);
        if (m_cnt[d] < 65535) m_cnt[d] = m_cnt[d] + 1;
        if (take && t == m_pc[d]) m_mode[d] = 2;
        else if (take)            m_pc[d] = t;
        else                      m_pc[d] = (m_pc[d] + 1) % modv;
      end else begin
        if (start) begin m_mode[d] = 1; m_pc[d] = 0; m_cnt[d] = 0; end
      end
    end
    if (reset) armed = 1'b1;
  end

  function automatic int exp_cc(input int d);
`ifdef FETCH_CYCLE_COUNT_EN
    return m_cnt[d];
`else
    return 0;
`endif
  endfunction

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      chk("pc0",      pc0,  m_pc[0]);
      chk("addr0",    a0,   m_pc[0]);
      chk("valid0",   iv0,  m_mode[0] == 1);
      chk("done0",    dn0,  m_mode[0] == 2);
      chk("opcode0",  op0,  rom_word(m_pc[0]) >> 5);
      chk("operand0", opr0, rom_word(m_pc[0]) & 31);
      chk("count0",   cc0,  exp_cc(0));
      chk("pc1",      pc1,  m_pc[1]);
      chk("addr1",    a1,   m_pc[1]);
      chk("valid1",   iv1,  m_mode[1] == 1);
      chk("done1",    dn1,  m_mode[1] == 2);
      chk("opcode1",  op1,  rom_word(m_pc[1]) >> 5);
      chk("operand1", opr1, rom_word(m_pc[1]) & 31);
      chk("count1",   cc1,  exp_cc(1));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic b, input logic [1:0] s, input logic e, input logic [9:0] t);
    br[0] = b; bsel[0] = s; eqf[0] = e; tgt[0] = t;
    @(posedge clk); #3;
    br[0] = 1'b0; bsel[0] = 2'd0; eqf[0] = 1'b0; tgt[0] = '0;
    br[1] = 1'b0; bsel[1] = 2'd0; eqf[1] = 1'b0; tgt[1] = '0;
    start = 1'b0;
  endtask

  task automatic nop();
    step(1'b0, 2'd0, 1'b0, 10'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      br[d] = 1'b0; bsel[d] = 2'd0; eqf[d] = 1'b0; tgt[d] = '0;
    end
    nop(); nop();
    chk("lit_reset_pc", pc0, 0);
    chk("lit_reset_valid", iv0, 0);
    chk("lit_reset_done", dn0, 0);
    chk("lit_reset_count", cc0, 0);
    reset = 1'b0;
    nop();
    chk("lit_idle_valid", iv0, 0);

    start = 1'b1; nop();
    chk("lit_first_pc", pc0, 0);
    chk("lit_first_valid", iv0, 1);
    nop(); nop(); nop();
    chk("lit_seq_pc3", pc0, 3);
    nop(); nop();
    chk("lit_seq_pc5", pc0, 5);

    step(1'b1, 2'd0, 1'b1, 10'd20);
    chk("lit_be_taken", pc0, 20);
    step(1'b1, 2'd2, 1'b0, 10'd5);
    step(1'b1, 2'd0, 1'b0, 10'd20);
    chk("lit_be_not_taken", pc0, 6);
    nop();
    step(1'b1, 2'd1, 1'b1, 10'd3);
    chk("lit_bne_not_taken", pc0, 8);
    step(1'b1, 2'd2, 1'b0, 10'd7);
    step(1'b1, 2'd1, 1'b0, 10'd3);
    chk("lit_bne_taken", pc0, 3);

    start = 1'b1; nop();
    chk("lit_start_in_run", pc0, 4);
    step(1'b1, 2'd3, 1'b1, 10'd4);
    chk("lit_sel3_pc", pc0, 5);
    chk("lit_sel3_no_halt", dn0, 0);

    step(1'b1, 2'd2, 1'b0, 10'd5);
    chk("lit_halt5_done", dn0, 1);
    chk("lit_halt5_pc", pc0, 5);
    step(1'b1, 2'd2, 1'b0, 10'd30);
    chk("lit_done_ignores_branch", pc0, 5);

    start = 1'b1; nop();
    chk("lit_restart_pc", pc0, 0);
    chk("lit_restart_done", dn0, 0);
    chk("lit_restart_count", cc0, 0);
    repeat (12) nop();
    chk("lit_pc12", pc0, 12);
    step(1'b1, 2'd2, 1'b0, 10'd12);
    chk("lit_halt12_done", dn0, 1);
    chk("lit_halt12_pc", pc0, 12);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("lit_halt12_count", cc0, 13);
`else
    chk("lit_halt12_count", cc0, 0);
`endif
    nop();
    chk("lit_done_hold_pc", pc0, 12);
    chk("lit_done_hold", dn0, 1);
    start = 1'b1; nop();
    chk("lit_after_done_pc", pc0, 0);
    chk("lit_after_done_done", dn0, 0);

    repeat (9) nop();
    chk("lit_pc9", pc0, 9);
    reset = 1'b1; nop();
    chk("lit_midrun_reset_pc", pc0, 0);
    chk("lit_midrun_reset_valid", iv0, 0);
    chk("lit_midrun_reset_count", cc0, 0);
    reset = 1'b0;
    nop();

    start = 1'b1; nop();
    chk("lit_small_start", pc1, 0);
    repeat (15) nop();
    chk("lit_small_pc15", pc1, 15);
    nop();
    chk("lit_small_wrap", pc1, 0);
    nop(); nop();
    chk("lit_small_pc2", pc1, 2);
    br[1] = 1'b1; bsel[1] = 2'd3; eqf[1] = 1'b1; tgt[1] = 10'd2;
    nop();
    chk("lit_small_sel3_pc", pc1, 3);
    chk("lit_small_sel3_done", dn1, 0);
    nop();

    @(posedge clk); #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle core: owns the program counter, presents the current 9-bit instruction to the control unit as opcode plus operand, and computes the next PC from the control unit's branch outputs. It sits directly upstream of the control unit and closes the loop on its `Branch`/`MUX7` decisions. It also runs the start/done program handshake with the testbench.

## Interface
Parameters:
- `PC_W`, 10, program counter and instruction memory address width
- `INSTR_W`, 9, instruction width; opcode is the top 4 bits, operand is the rest
- `START_ADDR`, 0, PC value after reset and on every program (re)start

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle pulse that begins program execution
- `imem_addr` out PC_W: instruction memory address, equal to `pc`
- `imem_data` in INSTR_W: instruction at `imem_addr`; combinational ROM, same-cycle
- `opcode` out 4: `imem_data[INSTR_W-1 -: 4]`
- `operand` out INSTR_W-4: `imem_data[INSTR_W-5:0]`
- `instr_valid` out 1: high only in RUN; downstream gates all writes with it
- `branch` in 1: `Branch` from the control unit
- `branch_sel` in 2: `MUX7` from the control unit (0 = be, 1 = bne, 2 = jump, 3 = reserved)
- `eq_flag` in 1: registered compare result from the datapath (set by `cmp`)
- `target` in PC_W: branch target from the datapath LUT
- `pc` out PC_W: current program counter
- `done` out 1: high while in DONE
- `cycle_count` out 16: count of instructions issued (see Configuration)

## Operation
- States:
  - IDLE: `pc` = START_ADDR, `instr_valid` = 0.
  - RUN: one instruction per cycle.
  - DONE: `pc` frozen, `done` = 1.
- Reset (any state, including mid-RUN): next edge → IDLE, `pc` = START_ADDR, `done` = 0, `cycle_count` = 0.
- IDLE + `start` → RUN. `pc` stays START_ADDR, so the first instruction issues in the first RUN cycle.
- RUN, each edge:
  - taken = `branch` & (sel 0: `eq_flag`; sel 1: !`eq_flag`; sel 2: 1; sel 3: 0).
  - Next `pc` = taken ? `target` : `pc` + 1. The increment wraps modulo 2^PC_W; the maximum address rolls over to 0.
- Halt: a taken branch whose `target` == `pc` → DONE; `pc` holds that value.
- DONE + `start` → RUN with `pc` = START_ADDR and `cycle_count` cleared.
- `start` in RUN is ignored.
- `branch` with sel 3 is not taken and is not a halt.
- Outside RUN, `branch`, `eq_flag` and `target` are ignored.

## Timing
- Single-cycle datapath: `branch`, `branch_sel`, `eq_flag` and `target` must be valid in the same cycle as the instruction that produces them. They are sampled at the edge that ends that cycle.
- `opcode`/`operand` are combinational from `imem_data`, with zero added latency.
- `done` rises on the edge following the halting instruction's cycle and stays high until `reset` or `start`.
- `instr_valid` rises one edge after `start` is sampled.
- Reset value of every output:
  - `pc`/`imem_addr` = START_ADDR
  - `instr_valid` = 0
  - `done` = 0
  - `cycle_count` = 0
  - `opcode`/`operand` follow `imem_data`

## Configuration
- `FETCH_CYCLE_COUNT_EN`:
  - Defined: `cycle_count` increments on every RUN edge, saturates at 16'hFFFF and holds in DONE.
  - Undefined: no counter logic is built and `cycle_count` is tied to 0; the port is kept.

## Structure
- Shared package `core_pkg`:
  - opcode enum (add … jump, 4-bit encodings 0000–1111)
  - branch-select constants `BR_EQ`=0, `BR_NE`=1, `BR_JMP`=2
  - fetch state enum (IDLE, RUN, DONE)
- One sub-module, `fetch_branch_resolve`: combinational; inputs `branch`, `branch_sel`, `eq_flag`, `target`, `pc`; outputs next PC and the halt flag.

## Test plan
- Reset, then `start` at cycle 2, straight-line program: `pc` goes 0,1,2,3 on successive RUN cycles; `instr_valid` = 1 from cycle 3.
- be at pc=5, `eq_flag`=1, `target`=20 → `pc`=20 next cycle. Same instruction with `eq_flag`=0 → `pc`=6.
- bne at pc=7, `eq_flag`=1 → `pc`=8. With `eq_flag`=0, `target`=3 → `pc`=3.
- Jump at pc=12 with `target`=12 → DONE, `done`=1, `pc` held at 12. With `FETCH_CYCLE_COUNT_EN` defined, `cycle_count`=13. A later `start` → `pc`=0, `done`=0.
- PC_W=4, straight-line code → `pc` goes 15→0. `branch`=1 with sel 3 at pc=2 → `pc`=3, no halt.
- `reset` asserted mid-RUN at pc=9 → next edge IDLE, `pc`=0, `instr_valid`=0, `cycle_count`=0. `start` asserted during RUN has no effect.
